// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Purpose: receiver FSM state type, parity-mode encodings and the default
//          bit period for a 100 MHz clock at 9600 bps (also used by the TX side).
// Ports:   none (package).
package uart_pkg;

  // 100 MHz / 9600 bps, rounded down.
  localparam int CLKS_PER_BIT_9600_100M = 10416;

  // Parity modes.
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Receiver FSM states. ST_BREAK_WAIT is only reachable when break
  // detection is compiled in.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_START      = 3'd1,
    ST_DATA       = 3'd2,
    ST_PARITY     = 3'd3,
    ST_STOP       = 3'd4,
    ST_BREAK_WAIT = 3'd5
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync_vote.sv
// RXD input conditioning.
// Purpose: brings the asynchronous serial line into the clock domain with a
//          2-FF synchroniser, keeps a 3-bit history of the synchronised value
//          and provides a 2-of-3 majority sample plus a falling-edge strobe.
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-high reset (flops reset to 1 = idle line)
//   i_rxd     in   raw serial line
//   o_sample  out  majority of the last three synchronised values
//   o_fall    out  synchronised line went 1 -> 0 this cycle
module uart_rx_sync_vote (
  input  logic clk,
  input  logic rst,
  input  logic i_rxd,
  output logic o_sample,
  output logic o_fall
);

  logic       r_sync1;
  logic       r_sync2;
  logic [2:0] r_hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_hist  <= 3'b111;
    end else begin
      r_sync1 <= i_rxd;
      r_sync2 <= r_sync1;
      r_hist  <= {r_hist[1:0], r_sync2};
    end
  end

  assign o_sample = (r_hist[0] & r_hist[1]) |
                    (r_hist[0] & r_hist[2]) |
                    (r_hist[1] & r_hist[2]);

  // r_hist[0] holds the previous synchronised value.
  assign o_fall = r_hist[0] & ~r_sync2;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver.
// Purpose: receives frames of DATA_BITS data bits (LSB first), optional
//          odd/even parity and 1 or 2 stop bits; majority-vote sampling at
//          bit mid-points; single-word output buffer with valid/ready.
// Optional feature (macro UART_RX_BREAK_DET_EN): an all-zero frame whose first
//          stop bit is 0 is reported as a break on o_break instead of being
//          delivered, and the receiver waits for one full bit time of idle
//          line before looking for a new start bit.
// Handshake: o_rx_valid rises when a word is loaded and stays high until the
//          cycle after o_rx_valid & i_rx_ready; o_rx_data and the error flags
//          are stable while o_rx_valid is high.
// Ports:
//   clk           in   system clock
//   rst           in   asynchronous active-high reset
//   RXD           in   serial line, idle high
//   o_rx_data     out  received word
//   o_rx_valid    out  word available
//   i_rx_ready    in   consumer accepts the word
//   o_parity_err  out  parity error for the current word
//   o_frame_err   out  a stop bit of the current word was sampled 0
//   o_overrun     out  1-cycle pulse: frame dropped because the buffer was full
//   o_break       out  1-cycle pulse: break detected (0 without the feature)
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_9600_100M,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = PAR_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RXD,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  input  logic                 i_rx_ready,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_break
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  logic w_sample;
  logic w_fall;

  uart_rx_sync_vote u_sync (
    .clk      (clk),
    .rst      (rst),
    .i_rxd    (RXD),
    .o_sample (w_sample),
    .o_fall   (w_fall)
  );

  rx_state_t              r_state,     w_state_n;
  logic [CW-1:0]          r_cnt,       w_cnt_n;
  logic [IW-1:0]          r_idx,       w_idx_n;
  logic [DATA_BITS-1:0]   r_shift,     w_shift_n;
  logic                   r_par_err,   w_par_err_n;
  logic                   r_frame_err, w_frame_err_n;
  logic                   r_stop_idx,  w_stop_idx_n;
  logic                   w_deliver;
  logic                   w_last_stop;
  logic                   w_par_xor;

  logic [DATA_BITS-1:0]   r_rx_data;
  logic                   r_rx_valid;
  logic                   r_out_perr;
  logic                   r_out_ferr;
  logic                   r_overrun;

`ifdef UART_RX_BREAK_DET_EN
  logic                   r_par_bit,   w_par_bit_n;
  logic                   w_break;
  logic                   r_break;
`endif

  assign w_last_stop = (STOP_BITS == 1) ? 1'b1 : r_stop_idx;
  // Even parity over data plus parity bit: 0 for a good even frame, 1 for odd.
  assign w_par_xor   = (^r_shift) ^ w_sample;

  // Receiver state register and frame datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_par_err   <= 1'b0;
      r_frame_err <= 1'b0;
      r_stop_idx  <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      r_par_bit   <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_n;
      r_cnt       <= w_cnt_n;
      r_idx       <= w_idx_n;
      r_shift     <= w_shift_n;
      r_par_err   <= w_par_err_n;
      r_frame_err <= w_frame_err_n;
      r_stop_idx  <= w_stop_idx_n;
`ifdef UART_RX_BREAK_DET_EN
      r_par_bit   <= w_par_bit_n;
`endif
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_cnt_n       = r_cnt + 1'b1;
    w_idx_n       = r_idx;
    w_shift_n     = r_shift;
    w_par_err_n   = r_par_err;
    w_frame_err_n = r_frame_err;
    w_stop_idx_n  = r_stop_idx;
    w_deliver     = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    w_par_bit_n   = r_par_bit;
    w_break       = 1'b0;
`endif

    case (r_state)
      ST_IDLE: begin
        w_cnt_n = '0;
        // Only an edge starts a frame; a line stuck low is ignored.
        if (w_fall) begin
          w_state_n = ST_START;
        end
      end

      ST_START: begin
        if (r_cnt == CNT_HALF) begin
          w_cnt_n = '0;
          if (!w_sample) begin
            w_state_n     = ST_DATA;
            w_idx_n       = '0;
            w_par_err_n   = 1'b0;
            w_frame_err_n = 1'b0;
            w_stop_idx_n  = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            w_par_bit_n   = 1'b0;
`endif
          end else begin
            // Start bit did not hold for half a bit: noise.
            w_state_n = ST_IDLE;
          end
        end
      end

      ST_DATA: begin
        if (r_cnt == CNT_FULL) begin
          w_cnt_n   = '0;
          w_shift_n = {w_sample, r_shift[DATA_BITS-1:1]};
          w_idx_n   = r_idx + 1'b1;
          if (r_idx == IDX_LAST) begin
            w_state_n = (PARITY_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
          end
        end
      end

      ST_PARITY: begin
        if (r_cnt == CNT_FULL) begin
          w_cnt_n     = '0;
          w_state_n   = ST_STOP;
          w_par_err_n = (PARITY_MODE == PAR_ODD) ? (w_par_xor != 1'b1)
                                                 : (w_par_xor != 1'b0);
`ifdef UART_RX_BREAK_DET_EN
          w_par_bit_n = w_sample;
`endif
        end
      end

      ST_STOP: begin
        if (r_cnt == CNT_FULL) begin
          w_cnt_n       = '0;
          w_frame_err_n = r_frame_err | ~w_sample;
`ifdef UART_RX_BREAK_DET_EN
          if (!r_stop_idx && !w_sample && (r_shift == '0) && !r_par_bit) begin
            w_break   = 1'b1;
            w_state_n = ST_BREAK_WAIT;
          end else
`endif
          if (w_last_stop) begin
            // Deliver at the stop mid-point so a following start edge is seen.
            w_deliver = 1'b1;
            w_state_n = ST_IDLE;
          end else begin
            w_stop_idx_n = 1'b1;
          end
        end
      end

`ifdef UART_RX_BREAK_DET_EN
      ST_BREAK_WAIT: begin
        // Need CLKS_PER_BIT consecutive high samples before re-arming.
        if (!w_sample) begin
          w_cnt_n = '0;
        end else if (r_cnt == CNT_FULL) begin
          w_cnt_n   = '0;
          w_state_n = ST_IDLE;
        end
      end
`endif

      default: begin
        w_state_n = ST_IDLE;
        w_cnt_n   = '0;
      end
    endcase
  end

  // Output buffer. A new word may overwrite the buffer in the same cycle the
  // old one is accepted; otherwise a full buffer drops the new frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_out_perr <= 1'b0;
      r_out_ferr <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_deliver) begin
        if (!r_rx_valid || i_rx_ready) begin
          r_rx_data  <= r_shift;
          r_out_perr <= r_par_err;
          r_out_ferr <= w_frame_err_n;
          r_rx_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_rx_valid && i_rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_break <= 1'b0;
    end else begin
      r_break <= w_break;
    end
  end
  assign o_break = r_break;
`else
  assign o_break = 1'b0;
`endif

  assign o_rx_data    = r_rx_data;
  assign o_rx_valid   = r_rx_valid;
  assign o_parity_err = r_out_perr;
  assign o_frame_err  = r_out_ferr;
  assign o_overrun    = r_overrun;

endmodule
